// File: rtl/spu_pre_stream_if.sv
// Stream bundle for the float -> 1.31 fixed converter.
//   in_valid/in_ready/in_float    : float samples into the converter
//   out_valid/out_ready/out_fixed : fixed-point samples out of the converter
//   out_flags                     : {nan, neg, sat, uflow} travelling with out_fixed
// master: the host side (drives input samples, accepts outputs).
// slave : the converter side.
interface spu_pre_stream_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_float;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_fixed;
  logic [3:0]  out_flags;

  modport master (
    output in_valid, in_float, out_ready,
    input  in_ready, out_valid, out_fixed, out_flags
  );

  modport slave (
    input  in_valid, in_float, out_ready,
    output in_ready, out_valid, out_fixed, out_flags
  );
endinterface

// File: rtl/spu_pre_stream.sv
// Streaming IEEE-754 single -> unsigned 1.31 fixed-point converter (bit31 = 2^0,
// bit0 = 2^-31). Two-stage valid/ready pipeline: stage 1 classifies the float and
// computes the shift, stage 2 performs the shift and holds the output.
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset
//   bus       : stream bundle (slave side), see spu_pre_stream_if
//   clr_count : synchronous clear of exc_count (wins over an increment)
//   exc_count : saturating count of flagged samples delivered downstream
module spu_pre_stream #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  spu_pre_stream_if.slave  bus,
  input  logic             clr_count,
  output logic [CNT_W-1:0] exc_count
);

  localparam logic [3:0] FlagNan   = 4'b1000;
  localparam logic [3:0] FlagNeg   = 4'b0100;
  localparam logic [3:0] FlagSat   = 4'b0010;
  localparam logic [3:0] FlagUflow = 4'b0001;

  // Stage 1 state
  logic        s1_valid_q, s1_valid_d;
  logic [22:0] s1_man_q, s1_man_d;
  logic [4:0]  s1_sh_q, s1_sh_d;
  logic [3:0]  s1_flags_q, s1_flags_d;
  logic        s1_zero_q, s1_zero_d;
  logic        s1_sat_q, s1_sat_d;

  // Stage 2 (output) state
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_fixed_q, out_fixed_d;
  logic [3:0]       out_flags_q, out_flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        in_sign;
  logic [7:0]  in_exp;
  logic [22:0] in_man;
  logic [3:0]  in_flags;
  logic        in_zero, in_sat;
  logic        s2_ready, s1_advance, in_ready, in_fire, out_fire;
  logic [31:0] shifted;

  assign in_sign = bus.in_float[31];
  assign in_exp  = bus.in_float[30:23];
  assign in_man  = bus.in_float[22:0];

  // Classification, highest priority first.
  always_comb begin
    in_flags = '0;
    in_zero  = 1'b0;
    in_sat   = 1'b0;
    if (in_exp == 8'hFF && in_man != '0) begin
      in_flags = FlagNan;
      in_zero  = 1'b1;
    end else if (in_exp == 8'h00 && in_man == '0) begin
      in_zero = 1'b1;
    end else if (in_sign) begin
      in_flags = FlagNeg;
      in_zero  = 1'b1;
    end else if (in_exp > 8'd127) begin
      in_flags = FlagSat;
      in_sat   = 1'b1;
    end else if (in_exp < 8'd96) begin
      in_flags = FlagUflow;
      in_zero  = 1'b1;
    end
  end

  assign s2_ready   = ~out_valid_q | bus.out_ready;
  assign s1_advance = s1_valid_q & s2_ready;
  assign in_ready   = ~s1_valid_q | s1_advance;
  assign in_fire    = bus.in_valid & in_ready;
  assign out_fire   = out_valid_q & bus.out_ready;

  assign shifted = {1'b1, s1_man_q, 8'b0} >> s1_sh_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_man_d   = s1_man_q;
    s1_sh_d    = s1_sh_q;
    s1_flags_d = s1_flags_q;
    s1_zero_d  = s1_zero_q;
    s1_sat_d   = s1_sat_q;
    if (in_ready) begin
      s1_valid_d = bus.in_valid;
    end
    if (in_fire) begin
      s1_man_d   = in_man;
      // For 96 <= e <= 127, 127 - e == 31 - (e - 96) == ~e[4:0].
      s1_sh_d    = ~in_exp[4:0];
      s1_flags_d = in_flags;
      s1_zero_d  = in_zero;
      s1_sat_d   = in_sat;
    end

    out_valid_d = out_valid_q;
    out_fixed_d = out_fixed_q;
    out_flags_d = out_flags_q;
    if (s2_ready) begin
      out_valid_d = s1_valid_q;
    end
    if (s1_advance) begin
      out_flags_d = s1_flags_q;
      if (s1_sat_q) begin
        out_fixed_d = '1;
      end else if (s1_zero_q) begin
        out_fixed_d = '0;
      end else begin
        out_fixed_d = shifted;
      end
    end

    cnt_d = cnt_q;
    if (clr_count) begin
      cnt_d = '0;
    end else if (out_fire && out_flags_q != '0 && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_man_q    <= '0;
      s1_sh_q     <= '0;
      s1_flags_q  <= '0;
      s1_zero_q   <= 1'b0;
      s1_sat_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_fixed_q <= '0;
      out_flags_q <= '0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_man_q    <= s1_man_d;
      s1_sh_q     <= s1_sh_d;
      s1_flags_q  <= s1_flags_d;
      s1_zero_q   <= s1_zero_d;
      s1_sat_q    <= s1_sat_d;
      out_valid_q <= out_valid_d;
      out_fixed_q <= out_fixed_d;
      out_flags_q <= out_flags_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_fixed = out_fixed_q;
  assign bus.out_flags = out_flags_q;
  assign exc_count     = cnt_q;

endmodule

// File: tb/tb_spu_pre_stream.sv
module tb_spu_pre_stream;

  localparam int unsigned CntW   = 2;
  localparam int          CntMax = (1 << CntW) - 1;

  typedef struct {
    logic [31:0] f;
    logic [31:0] fx;
    logic [3:0]  fl;
    bit          rt;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            clr_count;
  logic [CntW-1:0] exc_count;

  spu_pre_stream_if bus ();

  spu_pre_stream #(
    .CNT_W (CntW)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr_count (clr_count),
    .exc_count (exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t stim[$];
  bit   mon_on   = 1'b0;
  int   cnt_m    = 0;
  bit   saw_bp   = 1'b0;
  bit   prev_stall = 1'b0;
  bit   prev_rst   = 1'b0;
  logic [31:0] prev_fx;
  logic [3:0]  prev_fl;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: value = 1.m * 2^(e-127); fixed = floor(value * 2^31).
  function automatic void ref_conv(input logic [31:0] f, output logic [31:0] fx,
                                   output logic [3:0] fl);
    int     e;
    longint v;
    e  = int'(f[30:23]);
    fx = '0;
    fl = '0;
    if (e == 255 && f[22:0] != 0) begin
      fl = 4'b1000;
    end else if (e == 0 && f[22:0] == 0) begin
      fl = 4'b0000;
    end else if (f[31]) begin
      fl = 4'b0100;
    end else if (e > 127) begin
      fx = 32'hFFFF_FFFF;
      fl = 4'b0010;
    end else if (e < 96) begin
      fl = 4'b0001;
    end else begin
      v = longint'(32'h0080_0000 + 32'(f[22:0]));
      if (e >= 119) v = v << (e - 119);
      else          v = v >> (119 - e);
      fx = v[31:0];
    end
  endfunction

  // Post-stage model: fixed 1.31 -> float via leading-one position.
  function automatic logic [31:0] post(input logic [31:0] fx);
    int     p;
    longint w;
    p = -1;
    for (int i = 0; i < 32; i++) if (fx[i]) p = i;
    if (p < 0) return 32'h0;
    w = longint'(fx);
    if (p >= 23) w = w >> (p - 23);
    else         w = w << (23 - p);
    return {1'b0, 8'(96 + p), 23'(w & 64'h7F_FFFF)};
  endfunction

  function automatic exp_t mk(input logic [31:0] f, input logic [31:0] fx,
                              input logic [3:0] fl, input bit rt);
    exp_t r;
    r.f = f; r.fx = fx; r.fl = fl; r.rt = rt;
    return r;
  endfunction

  function automatic exp_t mk_ref(input logic [31:0] f, input bit rt);
    logic [31:0] fx;
    logic [3:0]  fl;
    ref_conv(f, fx, fl);
    return mk(f, fx, fl, rt);
  endfunction

  // Monitor: scoreboard, stall stability, counter model, backpressure observation.
  always @(negedge clk) begin
    exp_t e;
    bit   hs_flag;
    if (mon_on) begin
      chk("exc_count", 64'(exc_count), 64'(cnt_m));
      if (prev_stall && !prev_rst) begin
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_fixed", 64'(bus.out_fixed), 64'(prev_fx));
        chk("stall_flags", 64'(bus.out_flags), 64'(prev_fl));
      end
      hs_flag = 1'b0;
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_fixed", 64'(bus.out_fixed), 64'(e.fx));
          chk("out_flags", 64'(bus.out_flags), 64'(e.fl));
          if (e.rt) chk("roundtrip", 64'(post(bus.out_fixed)), 64'(e.f));
          hs_flag = (e.fl != 0);
        end
      end
      if (rst || clr_count) cnt_m = 0;
      else if (hs_flag && cnt_m < CntMax) cnt_m++;
      prev_stall = !rst && bus.out_valid && !bus.out_ready;
      prev_fx    = bus.out_fixed;
      prev_fl    = bus.out_flags;
      prev_rst   = rst;
      if (bus.in_valid && !bus.in_ready) saw_bp = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      tick();
      g++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Feed stim[] back-to-back. mode 0: out_ready low for cycles [s0, s0+sl); else random.
  task automatic stream(input int mode, input int s0, input int sl);
    int idx = 0;
    int cyc = 0;
    while (idx < stim.size() && cyc < 4000) begin
      if (mode == 0) bus.out_ready = !(cyc >= s0 && cyc < s0 + sl);
      else           bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid = 1'b1;
      bus.in_float = stim[idx].f;
      #1;
      if (bus.in_ready) begin
        exp_q.push_back(stim[idx]);
        idx++;
      end
      tick();
      cyc++;
    end
    chk("stream_sent", 64'(idx), 64'(stim.size()));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    stim.delete();
  endtask

  task automatic send_one(input logic [31:0] f);
    bus.in_valid = 1'b1;
    bus.in_float = f;
    #1;
    chk("send_ready", 64'(bus.in_ready), 64'd1);
    exp_q.push_back(mk_ref(f, 1'b0));
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int          lat;
    int          g;
    int          e;
    logic [22:0] m;
    logic [31:0] f;
    int          cnt_exp [5] = '{1, 2, 3, 3, 3};

    rst           = 1'b1;
    clr_count     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_float  = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_fixed", 64'(bus.out_fixed), 64'd0);
    chk("rst_out_flags", 64'(bus.out_flags), 64'd0);
    chk("rst_exc_count", 64'(exc_count), 64'd0);
    mon_on = 1'b1;
    rst    = 1'b0;
    tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // 1.0 -> 0x80000000 with two-cycle latency
    bus.in_valid = 1'b1;
    bus.in_float = 32'h3F80_0000;
    #1;
    chk("t1_in_ready", 64'(bus.in_ready), 64'd1);
    exp_q.push_back(mk(32'h3F80_0000, 32'h8000_0000, 4'h0, 1'b1));
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("t1_latency", 64'(lat), 64'd2);
    drain();

    // Directed boundary values with hand-derived expectations
    stim.push_back(mk(32'h3F00_0000, 32'h4000_0000, 4'h0, 1'b0));
    stim.push_back(mk(32'h3000_0000, 32'h0000_0001, 4'h0, 1'b0));
    stim.push_back(mk(32'h2F80_0000, 32'h0000_0000, 4'h1, 1'b0));
    stim.push_back(mk(32'h4000_0000, 32'hFFFF_FFFF, 4'h2, 1'b0));
    stim.push_back(mk(32'h7F80_0000, 32'hFFFF_FFFF, 4'h2, 1'b0));
    stim.push_back(mk(32'h7FC0_0000, 32'h0000_0000, 4'h8, 1'b0));
    stim.push_back(mk(32'hBF80_0000, 32'h0000_0000, 4'h4, 1'b0));
    stim.push_back(mk(32'h8000_0000, 32'h0000_0000, 4'h0, 1'b0));
    stim.push_back(mk(32'h0000_0001, 32'h0000_0000, 4'h1, 1'b0));
    stim.push_back(mk(32'h8000_0001, 32'h0000_0000, 4'h4, 1'b0));
    stream(0, 0, 0);

    // Six back-to-back samples with a five-cycle downstream stall
    for (int i = 0; i < 6; i++) begin
      e = $urandom_range(96, 127);
      m = 23'($urandom);
      stim.push_back(mk_ref({1'b0, 8'(e), m}, 1'b0));
    end
    saw_bp = 1'b0;
    stream(0, 2, 5);
    chk("t4_backpressure", 64'(saw_bp), 64'd1);

    // Saturating counter with a 2-bit width
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      stim.push_back(mk_ref(32'h7FC0_0001, 1'b0));
      stream(0, 0, 0);
      chk("t5_count", 64'(exc_count), 64'(cnt_exp[k]));
    end
    bus.out_ready = 1'b0;
    send_one(32'hBF80_0000);
    g = 0;
    while (!bus.out_valid && g < 10) begin
      tick();
      g++;
    end
    chk("t5_wait_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    clr_count     = 1'b1;
    tick();
    clr_count = 1'b0;
    chk("t5_clr", 64'(exc_count), 64'd0);
    drain();

    // Reset with both stages full
    stim.push_back(mk_ref(32'h4000_0000, 1'b0));
    stream(0, 0, 0);
    chk("t6_pre_count", 64'(exc_count), 64'd1);
    bus.out_ready = 1'b0;
    send_one(32'hBF80_0000);
    send_one(32'h7F80_0000);
    tick();
    chk("t6_full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("t6_full_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    chk("t6_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_exc_count", 64'(exc_count), 64'd0);
    chk("t6_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (4) tick();

    // Random sweep: arbitrary bit patterns, in-range positives, round-trip set
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0: stim.push_back(mk_ref($urandom, 1'b0));
        1: begin
          e = $urandom_range(96, 127);
          m = 23'($urandom);
          stim.push_back(mk_ref({1'b0, 8'(e), m}, 1'b0));
        end
        default: begin
          e = $urandom_range(104, 127);
          m = 23'($urandom);
          // Clear mantissa bits the 32-bit fixed format cannot hold at this exponent.
          if (e < 119) m = m & ~((23'd1 << (119 - e)) - 23'd1);
          f = {1'b0, 8'(e), m};
          stim.push_back(mk_ref(f, 1'b1));
        end
      endcase
    end
    stream(1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
